pwm_ramp_ctrl: RTL and testbench

Runtime controller for the team's free-running counter-compare PWM. It accepts a new duty target over a valid/ready handshake and owns the period counter and the live duty register. It moves the live duty toward the target either immediately or in bounded steps (soft-start / soft-stop), and only ever changes the duty on a period boundary, so no PWM period is ever truncated or glitched. It sits between a register/command source and the PWM pin.

---
 rtl/pwm_ramp_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Counter-compare PWM controller: owns the period counter and live duty, and moves
// the duty toward a commanded target (jump or bounded ramp) only on period boundaries.
module pwm_ramp_ctrl #(
  parameter int RESOLUTION   = 10,
  parameter int STEP         = 8,
  parameter int STEP_PERIODS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [RESOLUTION-1:0] cmd_duty,
  input  logic                  cmd_immediate,
  output logic                  pwm_out,
  output logic [RESOLUTION-1:0] duty_cur,
  output logic                  busy,
  output logic                  done
);

  localparam int DIFF_W = RESOLUTION + 1;
  localparam int DIV_W  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS + 1) : 1;

  localparam logic [RESOLUTION-1:0] CNT_MAX  = {RESOLUTION{1'b1}};
  localparam logic [DIFF_W-1:0]     STEP_V   = DIFF_W'(STEP);
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(STEP_PERIODS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MOVE = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [RESOLUTION-1:0]   cnt_r;
  logic [RESOLUTION-1:0]   duty_r;
  logic [RESOLUTION-1:0]   duty_s;
  logic [RESOLUTION-1:0]   target_r;
  logic                    mode_r;
  logic [DIV_W-1:0]        div_r;
  logic [DIV_W-1:0]        div_s;
  logic [DIV_W-1:0]        div_inc_s;
  logic                    done_r;
  logic                    done_s;
  logic                    pwm_r;
  logic                    boundary_s;
  logic                    accept_s;

  // One ramp step toward tgt, clamped so it never overshoots the target.
  function automatic logic [RESOLUTION-1:0] ramp_next(
    input logic [RESOLUTION-1:0] cur,
    input logic [RESOLUTION-1:0] tgt
  );
    logic [DIFF_W-1:0] diff;
    logic [DIFF_W-1:0] mag;
    logic [DIFF_W-1:0] stp;
    diff = {1'b0, tgt} - {1'b0, cur};
    if (diff[RESOLUTION]) begin
      mag = -diff;
    end else begin
      mag = diff;
    end
    if (mag < STEP_V) begin
      stp = mag;
    end else begin
      stp = STEP_V;
    end
    if (diff[RESOLUTION]) begin
      ramp_next = cur - stp[RESOLUTION-1:0];
    end else begin
      ramp_next = cur + stp[RESOLUTION-1:0];
    end
  endfunction

  assign boundary_s = enable && (cnt_r == CNT_MAX);
  assign accept_s   = cmd_valid && (state_r == IDLE);
  assign div_inc_s  = div_r + 1'b1;

  // Next-state, step divider and duty update decisions.
  always_comb begin
    state_s = state_r;
    div_s   = div_r;
    duty_s  = duty_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = MOVE;
          div_s   = {DIV_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      MOVE: begin
        // Stay in MOVE through the done cycle so a held command lands one cycle later.
        if (done_r) begin
          state_s = IDLE;
        end else if (boundary_s) begin
          if (mode_r || (div_inc_s == DIV_LAST)) begin
            div_s = {DIV_W{1'b0}};
            if (mode_r) begin
              duty_s = target_r;
            end else begin
              duty_s = ramp_next(duty_r, target_r);
            end
            done_s = (duty_s == target_r);
          end else begin
            div_s = div_inc_s;
          end
        end else begin
          state_s = MOVE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control state, divider, live duty and completion pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      div_r   <= {DIV_W{1'b0}};
      duty_r  <= {RESOLUTION{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      div_r   <= div_s;
      duty_r  <= duty_s;
      done_r  <= done_s;
    end
  end

  // Latch the command on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target_r <= {RESOLUTION{1'b0}};
      mode_r   <= 1'b0;
    end else if (accept_s) begin
      target_r <= cmd_duty;
      mode_r   <= cmd_immediate;
    end else begin
      target_r <= target_r;
      mode_r   <= mode_r;
    end
  end

  // Free-running period counter, frozen while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {RESOLUTION{1'b0}};
    end else if (enable) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Registered compare output, forced low while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_r <= 1'b0;
    end else begin
      pwm_r <= enable && (cnt_r < duty_r);
    end
  end

  assign pwm_out   = pwm_r;
  assign duty_cur  = duty_r;
  assign done      = done_r;
  assign busy      = (state_r == MOVE);
  assign cmd_ready = (state_r == IDLE);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl (RESOLUTION=4, STEP=3): scenario tasks plus randomized
// commands checked against an arithmetic duty/period model.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_valid4 = 1'b0;
  logic       cmd_imm = 1'b0;
  logic [3:0] cmd_duty = 4'd0;

  logic       ready1, busy1, done1, pwm1;
  logic [3:0] duty1;
  logic       ready4, busy4, done4, pwm4;
  logic [3:0] duty4;

  logic       s_ready, s_busy, s_done, s_pwm;
  logic [3:0] s_duty;
  bit         sel = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int m_duty [2];
  int m_cnt;
  bit m_bnd;

  pwm_ramp_ctrl #(.RESOLUTION(4), .STEP(3), .STEP_PERIODS(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(ready1),
    .cmd_duty(cmd_duty), .cmd_immediate(cmd_imm), .pwm_out(pwm1), .duty_cur(duty1),
    .busy(busy1), .done(done1)
  );

  pwm_ramp_ctrl #(.RESOLUTION(4), .STEP(3), .STEP_PERIODS(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .cmd_valid(cmd_valid4), .cmd_ready(ready4),
    .cmd_duty(cmd_duty), .cmd_immediate(cmd_imm), .pwm_out(pwm4), .duty_cur(duty4),
    .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (sel) begin
      s_ready = ready4; s_busy = busy4; s_done = done4; s_pwm = pwm4; s_duty = duty4;
    end else begin
      s_ready = ready1; s_busy = busy1; s_done = done1; s_pwm = pwm1; s_duty = duty1;
    end
  end

  // Period position model: m_bnd marks that the cycle just ended was a boundary.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt <= 0;
      m_bnd <= 1'b0;
    end else begin
      m_bnd <= enable && (m_cnt == 15);
      if (enable) m_cnt <= (m_cnt + 1) % 16;
    end
  end

  function automatic int model_step(input int cur, input int tgt);
    if (tgt - cur > 3) return cur + 3;
    if (cur - tgt > 3) return cur - 3;
    return tgt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input bit v);
    if (sel) cmd_valid4 = v;
    else cmd_valid = v;
  endtask

  task automatic run_cmd(input bit which, input int tgt, input bit imm,
                         input int freeze_after, input bit hold, input int hold_duty);
    int w, sp, expd, nb, upd, frz, cyc;
    bit fin, upd_now, exp_done, en_prev;
    sel = which;
    sp = which ? 4 : 1;
    frz = 0;
    w = 0;
    while (!s_ready && w < 200) begin tick(); w++; end
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_wait: cmd_ready=%b required 1", s_ready);
    end
    cmd_duty = 4'(tgt);
    cmd_imm = imm;
    set_valid(1'b1);
    if (freeze_after == 0) begin enable = 1'b0; frz = 50; end
    tick();
    if (hold) cmd_duty = 4'(hold_duty);
    else set_valid(1'b0);
    n_cmp++;
    if (s_busy !== 1'b1 || s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL accept: busy=%b ready=%b required busy=1 ready=0", s_busy, s_ready);
    end
    expd = m_duty[which];
    nb = 0; upd = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 3000) begin
      if (frz > 0) begin
        frz--;
        if (frz == 0) enable = 1'b1;
      end
      en_prev = enable;
      tick();
      cyc++;
      upd_now = 1'b0;
      if (m_bnd) begin
        nb++;
        if (imm ? (nb == 1) : (nb % sp == 0)) begin
          expd = imm ? tgt : model_step(expd, tgt);
          upd++;
          upd_now = 1'b1;
        end
      end
      exp_done = upd_now && (expd == tgt);
      n_cmp++;
      if (s_duty !== 4'(expd) || s_done !== exp_done || s_ready !== 1'b0 || s_busy !== 1'b1 ||
          (!en_prev && s_pwm !== 1'b0)) begin
        n_bad++;
        $display("FAIL move cyc%0d: duty=%0d done=%b ready=%b busy=%b pwm=%b required duty=%0d done=%b ready=0 busy=1 pwm_low=%b",
                 cyc, s_duty, s_done, s_ready, s_busy, s_pwm, expd, exp_done, !en_prev);
      end
      if (exp_done) fin = 1'b1;
      if (upd_now && upd == freeze_after && !fin) begin enable = 1'b0; frz = 50; end
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL move_timeout: target %0d not reached, duty=%0d", tgt, s_duty);
      enable = 1'b1;
    end
    m_duty[which] = tgt;
    tick();
    n_cmp++;
    if (s_done !== 1'b0 || s_busy !== 1'b0 || s_ready !== 1'b1 || s_duty !== 4'(tgt)) begin
      n_bad++;
      $display("FAIL after_done: done=%b busy=%b ready=%b duty=%0d required 0 0 1 %0d",
               s_done, s_busy, s_ready, s_duty, tgt);
    end
  endtask

  task automatic check_pwm(input int expd);
    int highs;
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (s_pwm === 1'b1) highs++;
    end
    n_cmp++;
    if (highs != expd) begin
      n_bad++;
      $display("FAIL pwm_highs: %0d high of 16, required %0d", highs, expd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enable = 1'b1;
    sel = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (s_pwm !== 1'b0 || s_duty !== 4'd0 || s_ready !== 1'b1 || s_busy !== 1'b0 || s_done !== 1'b0) begin
      n_bad++;
      $display("FAIL in_reset: pwm=%b duty=%0d ready=%b busy=%b done=%b required 0 0 1 0 0",
               s_pwm, s_duty, s_ready, s_busy, s_done);
    end
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_cmp++;
      if (s_pwm !== 1'b0 || s_duty !== 4'd0 || s_ready !== 1'b1 || s_busy !== 1'b0 || s_done !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_after_reset cyc%0d: pwm=%b duty=%0d ready=%b busy=%b done=%b required 0 0 1 0 0",
                 i, s_pwm, s_duty, s_ready, s_busy, s_done);
      end
    end
    m_duty[0] = 0;
    m_duty[1] = 0;
  endtask

  task automatic test_ramp_up();
    run_cmd(1'b0, 10, 1'b0, -1, 1'b0, 0);
    check_pwm(10);
  endtask

  task automatic test_ramp_down();
    run_cmd(1'b0, 2, 1'b0, -1, 1'b0, 0);
    check_pwm(2);
  endtask

  task automatic test_immediate();
    run_cmd(1'b0, 15, 1'b1, -1, 1'b0, 0);
    check_pwm(15);
    run_cmd(1'b1, 15, 1'b1, -1, 1'b0, 0);
    check_pwm(15);
  endtask

  task automatic test_back_to_back();
    run_cmd(1'b0, 10, 1'b0, -1, 1'b1, 5);
    run_cmd(1'b0, 5, 1'b0, -1, 1'b0, 0);
    check_pwm(5);
  endtask

  task automatic test_equal_duty();
    run_cmd(1'b0, 5, 1'b0, -1, 1'b0, 0);
    check_pwm(5);
  endtask

  task automatic test_enable_freeze();
    run_cmd(1'b0, 15, 1'b0, 1, 1'b0, 0);
    check_pwm(15);
    run_cmd(1'b0, 3, 1'b1, 0, 1'b0, 0);
    check_pwm(3);
  endtask

  task automatic test_reset_mid();
    int w;
    sel = 1'b0;
    cmd_duty = (m_duty[0] < 8) ? 4'd15 : 4'd0;
    cmd_imm = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    w = 0;
    do begin tick(); w++; end while (!m_bnd && w < 100);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (s_pwm !== 1'b0 || s_duty !== 4'd0 || s_ready !== 1'b1 || s_busy !== 1'b0 || s_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: pwm=%b duty=%0d ready=%b busy=%b done=%b required 0 0 1 0 0",
               s_pwm, s_duty, s_ready, s_busy, s_done);
    end
    tick();
    rst = 1'b1;
    m_duty[0] = 0;
    m_duty[1] = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_cmp++;
      if (s_done !== 1'b0 || s_duty !== 4'd0 || s_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL after_reset_mid cyc%0d: done=%b duty=%0d busy=%b required 0 0 0",
                 i, s_done, s_duty, s_busy);
      end
    end
  endtask

  task automatic test_random();
    bit which, imm;
    int tgt, frz;
    for (int k = 0; k < 10; k++) begin
      which = 1'($urandom_range(0, 1));
      tgt = int'($urandom_range(0, 15));
      imm = 1'($urandom_range(0, 1));
      frz = ($urandom_range(0, 3) == 0) ? 1 : -1;
      run_cmd(which, tgt, imm, frz, 1'b0, 0);
      check_pwm(tgt);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_immediate();
    test_back_to_back();
    test_equal_duty();
    test_enable_freeze();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
